// File: rtl/fifo_pkg.sv
// Shared constants and occupancy-state encoding for the sync FIFO, its stream reader and benches.
package fifo_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_BURST_LEN = 4;
    localparam int DEF_CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ONE  = 2'd1,
        ST_FULL = 2'd2
    } occ_state_e;

    function automatic logic [1:0] state_count(input occ_state_e s);
        case (s)
            ST_ONE:  return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order holding buffer; head entry is presented downstream.
// Caller guarantees no push while FULL unless a pop happens in the same cycle.
module skid_buf2 import fifo_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o,
    output logic [1:0]       count_o
);

    occ_state_e       state_q, state_d;
    logic [WIDTH-1:0] ent0_q, ent0_d;
    logic [WIDTH-1:0] ent1_q, ent1_d;

    always_comb begin
        state_d = state_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        case (state_q)
            ST_IDLE: begin
                if (push_i) begin
                    ent0_d  = push_dat_i;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push_i && pop_i) begin
                    ent0_d = push_dat_i;
                end else if (push_i) begin
                    ent1_d  = push_dat_i;
                    state_d = ST_FULL;
                end else if (pop_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FULL: begin
                if (pop_i) begin
                    ent0_d = ent1_q;
                    if (push_i) begin
                        ent1_d = push_dat_i;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ent0_q  <= '0;
            ent1_q  <= '0;
        end else begin
            state_q <= state_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
        end
    end

    assign vld_o   = (state_q != ST_IDLE);
    assign dat_o   = ent0_q;
    assign count_o = state_count(state_q);

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency sync FIFO into a valid/ready stream with burst framing and a beat count.
module fifo_stream_reader import fifo_pkg::*; #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_rdata_i,
    output logic             fifo_rd_en_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_last_o,
    output logic [CNT_W-1:0] beat_cnt_o
);

    localparam int            BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN - 1);

    logic             inflight_q, inflight_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic             pop;
    logic [1:0]       buf_cnt;
    logic [2:0]       occ_after;

    assign pop       = m_valid_o & m_ready_i;
    // Occupancy left after this cycle's pop; a pop always finds an entry, so no underflow.
    assign occ_after = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en_o = rst_ni & en_i & ~fifo_empty_i & (occ_after < 3'd2);

    skid_buf2 #(.WIDTH(WIDTH)) u_buf (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (inflight_q),
        .push_dat_i (fifo_rdata_i),
        .pop_i      (pop),
        .vld_o      (m_valid_o),
        .dat_o      (m_data_o),
        .count_o    (buf_cnt)
    );

    always_comb begin
        inflight_d = fifo_rd_en_o;
        burst_d    = burst_q;
        beat_d     = beat_q;
        if (pop) begin
            burst_d = (burst_q == BURST_MAX) ? '0 : burst_q + 1'b1;
            beat_d  = beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            inflight_q <= 1'b0;
            burst_q    <= '0;
            beat_q     <= '0;
        end else begin
            inflight_q <= inflight_d;
            burst_q    <= burst_d;
            beat_q     <= beat_d;
        end
    end

    assign m_last_o   = m_valid_o & (burst_q == BURST_MAX);
    assign beat_cnt_o = beat_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: behavioural upstream sync FIFO, per-cycle vector table and scoreboarded stream scenarios.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    localparam int BL = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en = 1'b0;
    logic        rdy = 1'b0;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        rd_en, m_valid, m_last;
    logic [7:0]  m_data;
    logic [15:0] beat_cnt;
    logic        rd_en4, m_valid4, m_last4;
    logic [7:0]  m_data4;
    logic [3:0]  beat_cnt4;

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(8), .BURST_LEN(BL), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en), .fifo_empty_i(fifo_empty),
        .fifo_rdata_i(fifo_rdata), .fifo_rd_en_o(rd_en), .m_valid_o(m_valid),
        .m_ready_i(rdy), .m_data_o(m_data), .m_last_o(m_last), .beat_cnt_o(beat_cnt)
    );

    fifo_stream_reader #(.WIDTH(8), .BURST_LEN(BL), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en), .fifo_empty_i(fifo_empty),
        .fifo_rdata_i(fifo_rdata), .fifo_rd_en_o(rd_en4), .m_valid_o(m_valid4),
        .m_ready_i(rdy), .m_data_o(m_data4), .m_last_o(m_last4), .beat_cnt_o(beat_cnt4)
    );

    // Upstream sync FIFO: read data appears the cycle after rd_en, sticky rd_error on empty read.
    logic       wr_en = 1'b0;
    logic [7:0] wr_dat = 8'h00;
    logic [7:0] fmem [32];
    logic [4:0] wp = '0, rp = '0;
    int         fcnt = 0;
    logic       rd_err = 1'b0;
    logic [7:0] rdata_q = 8'h00;

    assign fifo_empty = (fcnt == 0);
    assign fifo_rdata = rdata_q;

    always @(posedge clk) begin
        if (rd_en && fcnt == 0) rd_err <= 1'b1;
        if (rd_en && fcnt != 0) begin
            rdata_q <= fmem[rp];
            rp      <= rp + 5'd1;
        end
        if (wr_en) begin
            fmem[wp] <= wr_dat;
            wp       <= wp + 5'd1;
        end
        fcnt <= fcnt + (wr_en ? 1 : 0) - ((rd_en && fcnt != 0) ? 1 : 0);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard state: everything pushed into the FIFO, in order, not yet accepted downstream.
    logic [7:0] exp_q[$];
    int         cyc = 0;
    int         reads = 0, acc = 0, burst = 0, lasts = 0;
    int         first_rd = -1, first_x = -1, last_x = -1;
    logic       stall_prev = 1'b0;
    logic [7:0] prev_dat = 8'h00;
    logic       prev_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_ni) begin
            stall_prev = 1'b0;
        end else begin
            logic pop;
            pop = m_valid && rdy;
            if (rd_en && fifo_empty) chk("mon_rd_when_empty", 1, 0);
            if ((reads + int'(rd_en)) - (acc + int'(pop)) > 2) chk("mon_occupancy", reads - acc, 2);
            if (!m_valid && m_last) chk("mon_last_without_valid", m_last, 0);
            if (stall_prev) begin
                chk("mon_hold_valid", m_valid, 1);
                chk("mon_hold_data", m_data, prev_dat);
                chk("mon_hold_last", m_last, prev_last);
            end
            if (rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                reads++;
            end
            if (pop) begin
                if (exp_q.size() == 0) begin
                    chk("mon_unexpected_beat", 1, 0);
                end else begin
                    chk("mon_data", m_data, exp_q.pop_front());
                end
                chk("mon_last", m_last, (burst == BL - 1) ? 1 : 0);
                chk("mon_beat_cnt", beat_cnt, acc);
                if (m_last) lasts++;
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
                acc++;
                burst = (burst + 1) % BL;
            end
            stall_prev = m_valid && !rdy;
            prev_dat   = m_data;
            prev_last  = m_last;
        end
    end

    task automatic preload(input int n, input logic [7:0] base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            wr_en  = 1'b1;
            wr_dat = rnd ? 8'($urandom_range(0, 255)) : base + 8'(i * 8'h11);
            exp_q.push_back(wr_dat);
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Caller sets en/rdy; data held in the reader when the edge hits is removed from the scoreboard.
    task automatic do_reset();
        int drop;
        @(posedge clk); #1;
        rst_ni = 1'b0;
        @(negedge clk);
        chk("rst_rd_en_low", rd_en, 0);
        drop = reads - acc;
        for (int k = 0; k < drop; k++) if (exp_q.size() != 0) void'(exp_q.pop_front());
        reads = 0; acc = 0; burst = 0; lasts = 0;
        first_rd = -1; first_x = -1; last_x = -1;
        @(posedge clk); #1;
        rst_ni = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    typedef struct {
        logic        en;
        logic        rdy;
        logic        exp_rd;
        logic        exp_vld;
        logic [7:0]  exp_dat;
        logic        exp_last;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int snap_rd, snap_acc, waited;
        logic [7:0] a3;

        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 16'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 16'd0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 16'd1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 16'd2};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 16'd2};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 16'd3};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd4};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd4};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd4};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 16'd4};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd5};

        // Reset state
        repeat (2) @(posedge clk);
        do_reset();
        @(negedge clk);
        chk("reset_valid", m_valid, 0);
        chk("reset_last", m_last, 0);
        chk("reset_data", m_data, 0);
        chk("reset_beat_cnt", beat_cnt, 0);
        chk("reset_rd_en", rd_en, 0);

        // Cycle-exact vectors over 11,22,33,44,55
        preload(5, 8'h11, 1'b0);
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            en  = tbl[i].en;
            rdy = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_rd_en", i), rd_en, tbl[i].exp_rd);
            chk($sformatf("vec%0d_valid", i), m_valid, tbl[i].exp_vld);
            if (tbl[i].exp_vld) chk($sformatf("vec%0d_data", i), m_data, tbl[i].exp_dat);
            chk($sformatf("vec%0d_last", i), m_last, tbl[i].exp_last);
            chk($sformatf("vec%0d_beat_cnt", i), beat_cnt, tbl[i].exp_cnt);
        end

        // Reset with one beat buffered and one read in flight
        @(posedge clk); #1; en = 1'b0; rdy = 1'b0;
        preload(4, 8'hA1, 1'b0);
        a3 = exp_q[2];
        @(posedge clk); #1; en = 1'b1;
        @(posedge clk); #1;
        do_reset();
        rdy = 1'b1;
        @(negedge clk);
        chk("rstmid_valid", m_valid, 0);
        chk("rstmid_beat_cnt", beat_cnt, 0);
        chk("rstmid_last", m_last, 0);
        waited = 0;
        while (!(m_valid && rdy) && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("rstmid_first_beat_seen", (m_valid && rdy) ? 1 : 0, 1);
        chk("rstmid_first_data", m_data, a3);
        chk("rstmid_first_last", m_last, 0);
        chk("rstmid_first_cnt", beat_cnt, 0);
        drain("rstmid_drain", 20);

        // Empty FIFO with enable held
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("empty_rd_en", rd_en, 0);
            chk("empty_valid", m_valid, 0);
        end
        chk("empty_rd_error", rd_err, 0);

        // Enable drops one cycle after the first read
        en = 1'b0;
        preload(4, 8'hB1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        snap_rd = reads; snap_acc = acc;
        en = 1'b1;
        @(negedge clk);
        chk("endrop_first_rd", rd_en, 1);
        @(posedge clk); #1; en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("endrop_reads", reads - snap_rd, 1);
        chk("endrop_beats", acc - snap_acc, 1);
        chk("endrop_left_in_fifo", fcnt, 3);
        en = 1'b1;
        drain("endrop_drain", 20);

        // Full-rate stream of 16 random bytes
        en = 1'b0;
        do_reset();
        preload(16, 8'h00, 1'b1);
        en = 1'b1; rdy = 1'b1;
        drain("stream_drain", 60);
        chk("stream_beats", acc, 16);
        chk("stream_lasts", lasts, 4);
        chk("stream_beat_cnt", beat_cnt, 16);
        chk("stream_fill_latency", first_x - first_rd, 2);
        chk("stream_back_to_back", last_x - first_x, 15);

        // Backpressure 1-0-0-1
        en = 1'b0;
        preload(16, 8'h00, 1'b1);
        en = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            rdy = (i % 4 == 0 || i % 4 == 3);
            @(posedge clk); #1;
        end
        chk("bp_all_delivered", exp_q.size(), 0);
        chk("bp_beat_cnt", beat_cnt, 32);

        // Beat counter wrap with a 4-bit counter
        en = 1'b0; rdy = 1'b1;
        do_reset();
        preload(17, 8'h00, 1'b1);
        en = 1'b1;
        drain("wrap_drain", 60);
        chk("wrap_cnt4", beat_cnt4, 1);
        chk("wrap_cnt16", beat_cnt, 17);

        chk("final_rd_error", rd_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
